// File: rtl/ram_bridge.sv
// ram_bridge: arbitrates CPU read/write/refresh level requests and a loader
// write strobe onto a single-command SDRAM controller port. CPU levels are
// edge-detected into pending flags. A three-state FSM (IDLE/CMD/WAIT) issues
// one command at a time, then waits out the controller latency.
module ram_bridge #(
    parameter int AW  = 18,
    parameter int LAT = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ready,
    input  logic          rfsh,
    input  logic          ramRd,
    input  logic          ramWr,
    input  logic [AW-1:0] ramA,
    input  logic [7:0]    ramD,
    output logic [7:0]    ramQ,
    input  logic          ldWr,
    input  logic [AW-1:0] ldA,
    input  logic [7:0]    ldD,
    output logic          ldBusy,
    output logic          sdrRf,
    output logic          sdrRd,
    output logic          sdrWr,
    output logic [23:0]   sdrA,
    output logic [15:0]   sdrD,
    input  logic [15:0]   sdrQ
);

    localparam int CW   = $clog2(LAT + 1);
    localparam int PADW = 24 - AW;

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
    typedef enum logic [1:0] {SEL_RD, SEL_WR, SEL_RF, SEL_LD} sel_t;

    state_t        state_reg, state_next;
    sel_t          sel_reg, win_sel;
    logic [CW-1:0] cnt_reg;

    logic          rfsh_prev_reg, rd_prev_reg, wr_prev_reg, armed_reg;
    logic          p_rd_reg, p_wr_reg, p_rf_reg, p_ld_reg;
    logic [AW-1:0] rd_a_reg, wr_a_reg, ld_a_reg;
    logic [7:0]    wr_d_reg, ld_d_reg;

    logic          rd_edge, wr_edge, rf_edge, ld_take;
    logic          go, wait_done;
    logic          sdr_rf_next, sdr_rd_next, sdr_wr_next;
    logic [23:0]   sdr_a_next;
    logic [15:0]   sdr_d_next;

    // Only the low byte of the SDRAM read word carries data.
    logic          unused_q;
    assign unused_q = ^sdrQ[15:8];

    // Edges are ignored for the first cycle after reset so that levels held
    // high through reset do not look like fresh requests.
    assign rd_edge = armed_reg & ramRd & ~rd_prev_reg;
    assign wr_edge = armed_reg & ramWr & ~wr_prev_reg;
    assign rf_edge = armed_reg & rfsh  & ~rfsh_prev_reg;
    assign ld_take = ldWr & ~ldBusy;

    // The loader strobe is a single-cycle pulse, so IDLE may serve it in the
    // same cycle it is accepted instead of waiting for the pending flag.
    assign go = (state_reg == IDLE) && ready &&
                (p_rd_reg || p_wr_reg || p_rf_reg || p_ld_reg || ld_take);

    // WAIT ends on the cycle the counter decrements to zero.
    assign wait_done = (state_reg == WAIT) && (cnt_reg <= CW'(1));

    // Fixed-priority arbitration: read, write, refresh, loader.
    always_comb begin
        win_sel = SEL_LD;
        if (p_rd_reg)      win_sel = SEL_RD;
        else if (p_wr_reg) win_sel = SEL_WR;
        else if (p_rf_reg) win_sel = SEL_RF;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (go) state_next = CMD;
            CMD:     state_next = WAIT;
            WAIT:    if (wait_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output logic: command pulse and address/data for the next CMD cycle.
    always_comb begin
        sdr_rf_next = 1'b0;
        sdr_rd_next = 1'b0;
        sdr_wr_next = 1'b0;
        sdr_a_next  = sdrA;
        sdr_d_next  = sdrD;
        if (go) begin
            case (win_sel)
                SEL_RD: begin
                    sdr_rd_next = 1'b1;
                    sdr_a_next  = {{PADW{1'b0}}, rd_a_reg};
                end
                SEL_WR: begin
                    sdr_wr_next = 1'b1;
                    sdr_a_next  = {{PADW{1'b0}}, wr_a_reg};
                    sdr_d_next  = {2{wr_d_reg}};
                end
                SEL_RF: begin
                    sdr_rf_next = 1'b1;
                end
                default: begin
                    sdr_wr_next = 1'b1;
                    sdr_a_next  = {{PADW{1'b0}}, (p_ld_reg ? ld_a_reg : ldA)};
                    sdr_d_next  = {2{(p_ld_reg ? ld_d_reg : ldD)}};
                end
            endcase
        end
    end

    // Request capture, pending flags, wait counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rfsh_prev_reg <= 1'b0;
            rd_prev_reg   <= 1'b0;
            wr_prev_reg   <= 1'b0;
            armed_reg     <= 1'b0;
            p_rd_reg      <= 1'b0;
            p_wr_reg      <= 1'b0;
            p_rf_reg      <= 1'b0;
            p_ld_reg      <= 1'b0;
            rd_a_reg      <= '0;
            wr_a_reg      <= '0;
            wr_d_reg      <= '0;
            ld_a_reg      <= '0;
            ld_d_reg      <= '0;
            sel_reg       <= SEL_RD;
            cnt_reg       <= '0;
            ramQ          <= 8'h00;
            ldBusy        <= 1'b0;
            sdrRf         <= 1'b0;
            sdrRd         <= 1'b0;
            sdrWr         <= 1'b0;
            sdrA          <= '0;
            sdrD          <= '0;
        end else begin
            rfsh_prev_reg <= rfsh;
            rd_prev_reg   <= ramRd;
            wr_prev_reg   <= ramWr;
            armed_reg     <= 1'b1;

            if (state_reg == CMD && sel_reg == SEL_RD) begin
                p_rd_reg <= 1'b0;
            end else if (rd_edge && !p_rd_reg) begin
                p_rd_reg <= 1'b1;
                rd_a_reg <= ramA;
            end

            if (state_reg == CMD && sel_reg == SEL_WR) begin
                p_wr_reg <= 1'b0;
            end else if (wr_edge && !p_wr_reg) begin
                p_wr_reg <= 1'b1;
                wr_a_reg <= ramA;
                wr_d_reg <= ramD;
            end

            if (state_reg == CMD && sel_reg == SEL_RF) begin
                p_rf_reg <= 1'b0;
            end else if (rf_edge && !p_rf_reg) begin
                p_rf_reg <= 1'b1;
            end

            if (state_reg == CMD && sel_reg == SEL_LD) begin
                p_ld_reg <= 1'b0;
            end else if (ld_take) begin
                p_ld_reg <= 1'b1;
                ld_a_reg <= ldA;
                ld_d_reg <= ldD;
            end

            if (ld_take) begin
                ldBusy <= 1'b1;
            end else if (wait_done && sel_reg == SEL_LD) begin
                ldBusy <= 1'b0;
            end

            if (go) sel_reg <= win_sel;

            if (state_reg == CMD) begin
                cnt_reg <= CW'(LAT - 1);
            end else if (state_reg == WAIT && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CW'(1);
            end

            if (wait_done && sel_reg == SEL_RD) ramQ <= sdrQ[7:0];

            sdrRf <= sdr_rf_next;
            sdrRd <= sdr_rd_next;
            sdrWr <= sdr_wr_next;
            sdrA  <= sdr_a_next;
            sdrD  <= sdr_d_next;
        end
    end

endmodule

// File: tb/tb_ram_bridge.sv
// Directed testbench for ram_bridge: one task per scenario, each with its own
// inline checks against hand-computed cycle offsets and data values.
module tb_ram_bridge;

    localparam int AW  = 18;
    localparam int LAT = 8;

    logic          clock, reset, ready, rfsh, ramRd, ramWr, ldWr;
    logic [AW-1:0] ramA, ldA;
    logic [7:0]    ramD, ldD, ramQ;
    logic          ldBusy, sdrRf, sdrRd, sdrWr;
    logic [23:0]   sdrA;
    logic [15:0]   sdrD, sdrQ;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap_cnt = 0;

    // Command pulse log: kind 0=refresh, 1=read, 2=write.
    int          pc_cyc[$];
    int          pc_kind[$];
    logic [23:0] pc_a[$];
    logic [15:0] pc_d[$];

    ram_bridge #(.AW(AW), .LAT(LAT)) dut (
        .clock(clock), .reset(reset), .ready(ready), .rfsh(rfsh),
        .ramRd(ramRd), .ramWr(ramWr), .ramA(ramA), .ramD(ramD), .ramQ(ramQ),
        .ldWr(ldWr), .ldA(ldA), .ldD(ldD), .ldBusy(ldBusy),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr),
        .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if ((int'(sdrRf) + int'(sdrRd) + int'(sdrWr)) > 1) overlap_cnt++;
        if (sdrRf || sdrRd || sdrWr) begin
            pc_cyc.push_back(cyc);
            pc_kind.push_back(sdrRd ? 1 : (sdrWr ? 2 : 0));
            pc_a.push_back(sdrA);
            pc_d.push_back(sdrD);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        pc_cyc.delete();
        pc_kind.delete();
        pc_a.delete();
        pc_d.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; ready = 1'b1; rfsh = 1'b0; ramRd = 1'b0; ramWr = 1'b0;
        ramA = '0; ramD = '0; ldWr = 1'b0; ldA = '0; ldD = '0; sdrQ = '0;
        tick(3);
        checks++; if (ramQ !== 8'h00) begin errors++; $display("FAIL reset_ramQ got=%h exp=00", ramQ); end
        checks++; if (ldBusy !== 1'b0) begin errors++; $display("FAIL reset_ldBusy got=%b exp=0", ldBusy); end
        checks++; if ({sdrRf, sdrRd, sdrWr} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {sdrRf, sdrRd, sdrWr}); end
        checks++; if (sdrA !== 24'h0) begin errors++; $display("FAIL reset_sdrA got=%h exp=000000", sdrA); end
        checks++; if (sdrD !== 16'h0) begin errors++; $display("FAIL reset_sdrD got=%h exp=0000", sdrD); end
        reset = 1'b1;
        tick(2);
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_read();
        int k;
        int got;
        got = -1;
        clear_log();
        ramA = 18'h04000; sdrQ = 16'h00A5; ramRd = 1'b1; k = cyc;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (got < 0 && ramQ === 8'hA5) got = cyc - k;
        end
        ramRd = 1'b0;
        tick(2);
        checks++; if (got !== LAT + 2) begin errors++; $display("FAIL read_latency got=%0d exp=%0d", got, LAT + 2); end
        checks++; if (pc_cyc.size() !== 1) begin errors++; $display("FAIL read_pulse_count got=%0d exp=1", pc_cyc.size()); end
        if (pc_cyc.size() >= 1) begin
            checks++; if (pc_kind[0] !== 1) begin errors++; $display("FAIL read_kind got=%0d exp=1", pc_kind[0]); end
            checks++; if (pc_a[0] !== 24'h004000) begin errors++; $display("FAIL read_sdrA got=%h exp=004000", pc_a[0]); end
            checks++; if (pc_cyc[0] - k !== 2) begin errors++; $display("FAIL read_cmd_offset got=%0d exp=2", pc_cyc[0] - k); end
        end
        $display("read: A=04000 ramQ=%h latency=%0d", ramQ, got);
    endtask

    task automatic test_write();
        int k;
        clear_log();
        ramA = 18'h1FFFF; ramD = 8'h3C; ramWr = 1'b1; k = cyc;
        tick(14);
        ramWr = 1'b0;
        tick(2);
        checks++; if (pc_cyc.size() !== 1) begin errors++; $display("FAIL write_pulse_count got=%0d exp=1", pc_cyc.size()); end
        if (pc_cyc.size() >= 1) begin
            checks++; if (pc_kind[0] !== 2) begin errors++; $display("FAIL write_kind got=%0d exp=2", pc_kind[0]); end
            checks++; if (pc_a[0] !== 24'h01FFFF) begin errors++; $display("FAIL write_sdrA got=%h exp=01ffff", pc_a[0]); end
            checks++; if (pc_d[0] !== 16'h3C3C) begin errors++; $display("FAIL write_sdrD got=%h exp=3c3c", pc_d[0]); end
            checks++; if (pc_cyc[0] - k !== 2) begin errors++; $display("FAIL write_cmd_offset got=%0d exp=2", pc_cyc[0] - k); end
        end
        checks++; if (ramQ !== 8'hA5) begin errors++; $display("FAIL write_ramQ_held got=%h exp=a5", ramQ); end
        $display("write: A=1FFFF D=3C pulses=%0d", pc_cyc.size());
    endtask

    task automatic test_rd_rf();
        int k;
        clear_log();
        ramA = 18'h00123; sdrQ = 16'h005A; ramRd = 1'b1; rfsh = 1'b1; k = cyc;
        tick(20);
        ramRd = 1'b0; rfsh = 1'b0;
        tick(2);
        checks++; if (pc_cyc.size() !== 2) begin errors++; $display("FAIL rdrf_pulse_count got=%0d exp=2", pc_cyc.size()); end
        if (pc_cyc.size() >= 2) begin
            checks++; if (pc_kind[0] !== 1 || pc_kind[1] !== 0) begin errors++; $display("FAIL rdrf_order got=%0d,%0d exp=1,0", pc_kind[0], pc_kind[1]); end
            checks++; if (pc_cyc[0] - k !== 2) begin errors++; $display("FAIL rdrf_rd_offset got=%0d exp=2", pc_cyc[0] - k); end
            checks++; if (pc_cyc[1] - pc_cyc[0] !== LAT + 1) begin errors++; $display("FAIL rdrf_spacing got=%0d exp=%0d", pc_cyc[1] - pc_cyc[0], LAT + 1); end
            checks++; if (pc_a[0] !== 24'h000123) begin errors++; $display("FAIL rdrf_sdrA got=%h exp=000123", pc_a[0]); end
        end
        checks++; if (ramQ !== 8'h5A) begin errors++; $display("FAIL rdrf_ramQ got=%h exp=5a", ramQ); end
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rdrf_overlap got=%0d exp=0", overlap_cnt); end
        $display("rd+rf: pulses=%0d ramQ=%h", pc_cyc.size(), ramQ);
    endtask

    task automatic test_loader();
        int k;
        logic busy0;
        busy0 = 1'b0;
        clear_log();
        k = cyc;
        for (int i = 0; i < 20; i++) begin
            ldWr = 1'b1; ldA = 18'(18'h100 + i); ldD = 8'(8'h10 + i);
            tick(1);
            if (i == 0) busy0 = ldBusy;
        end
        ldWr = 1'b0;
        tick(12);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ld_busy_set got=%b exp=1", busy0); end
        checks++; if (ldBusy !== 1'b0) begin errors++; $display("FAIL ld_busy_clear got=%b exp=0", ldBusy); end
        checks++; if (pc_cyc.size() !== 3) begin errors++; $display("FAIL ld_pulse_count got=%0d exp=3", pc_cyc.size()); end
        if (pc_cyc.size() >= 3) begin
            checks++; if (pc_cyc[0] - k !== 1 || pc_cyc[1] - k !== 10 || pc_cyc[2] - k !== 19) begin
                errors++; $display("FAIL ld_offsets got=%0d,%0d,%0d exp=1,10,19", pc_cyc[0] - k, pc_cyc[1] - k, pc_cyc[2] - k); end
            checks++; if (pc_a[0] !== 24'h000100 || pc_a[1] !== 24'h000109 || pc_a[2] !== 24'h000112) begin
                errors++; $display("FAIL ld_sdrA got=%h,%h,%h exp=000100,000109,000112", pc_a[0], pc_a[1], pc_a[2]); end
            checks++; if (pc_d[0] !== 16'h1010 || pc_d[1] !== 16'h1919 || pc_d[2] !== 16'h2222) begin
                errors++; $display("FAIL ld_sdrD got=%h,%h,%h exp=1010,1919,2222", pc_d[0], pc_d[1], pc_d[2]); end
            checks++; if (pc_kind[0] !== 2 || pc_kind[1] !== 2 || pc_kind[2] !== 2) begin
                errors++; $display("FAIL ld_kind got=%0d,%0d,%0d exp=2,2,2", pc_kind[0], pc_kind[1], pc_kind[2]); end
        end
        $display("loader: pulses=%0d", pc_cyc.size());
    endtask

    task automatic test_ready();
        int m;
        int n0;
        clear_log();
        ready = 1'b0; ramA = 18'h00777; sdrQ = 16'h0011; ramRd = 1'b1; rfsh = 1'b1;
        tick(12);
        n0 = pc_cyc.size();
        ready = 1'b1; m = cyc;
        tick(20);
        ramRd = 1'b0; rfsh = 1'b0;
        tick(2);
        checks++; if (n0 !== 0) begin errors++; $display("FAIL rdy_blocked got=%0d exp=0", n0); end
        checks++; if (pc_cyc.size() !== 2) begin errors++; $display("FAIL rdy_pulse_count got=%0d exp=2", pc_cyc.size()); end
        if (pc_cyc.size() >= 2) begin
            checks++; if (pc_kind[0] !== 1 || pc_kind[1] !== 0) begin errors++; $display("FAIL rdy_order got=%0d,%0d exp=1,0", pc_kind[0], pc_kind[1]); end
            checks++; if (pc_cyc[0] - m !== 1) begin errors++; $display("FAIL rdy_first_offset got=%0d exp=1", pc_cyc[0] - m); end
            checks++; if (pc_cyc[1] - pc_cyc[0] !== LAT + 1) begin errors++; $display("FAIL rdy_spacing got=%0d exp=%0d", pc_cyc[1] - pc_cyc[0], LAT + 1); end
            checks++; if (pc_a[0] !== 24'h000777) begin errors++; $display("FAIL rdy_sdrA got=%h exp=000777", pc_a[0]); end
        end
        checks++; if (ramQ !== 8'h11) begin errors++; $display("FAIL rdy_ramQ got=%h exp=11", ramQ); end
        $display("ready: blocked=%0d served=%0d", n0, pc_cyc.size());
    endtask

    task automatic test_reset_mid();
        clear_log();
        ramA = 18'h00200; sdrQ = 16'h00EE; ramRd = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(1);
        checks++; if (ramQ !== 8'h00) begin errors++; $display("FAIL rmid_ramQ got=%h exp=00", ramQ); end
        checks++; if ({sdrRf, sdrRd, sdrWr} !== 3'b000) begin errors++; $display("FAIL rmid_pulses got=%b exp=000", {sdrRf, sdrRd, sdrWr}); end
        checks++; if (sdrA !== 24'h0 || sdrD !== 16'h0) begin errors++; $display("FAIL rmid_addr_data got=%h/%h exp=000000/0000", sdrA, sdrD); end
        checks++; if (ldBusy !== 1'b0) begin errors++; $display("FAIL rmid_ldBusy got=%b exp=0", ldBusy); end
        tick(3);
        reset = 1'b1;
        clear_log();
        tick(15);
        checks++; if (pc_cyc.size() !== 0) begin errors++; $display("FAIL rmid_no_edge got=%0d exp=0", pc_cyc.size()); end
        checks++; if (ramQ !== 8'h00) begin errors++; $display("FAIL rmid_ramQ_after got=%h exp=00", ramQ); end
        ramRd = 1'b0;
        tick(2);
        ramRd = 1'b1;
        tick(14);
        ramRd = 1'b0;
        checks++; if (pc_cyc.size() !== 1) begin errors++; $display("FAIL rmid_rearm_count got=%0d exp=1", pc_cyc.size()); end
        checks++; if (ramQ !== 8'hEE) begin errors++; $display("FAIL rmid_rearm_ramQ got=%h exp=ee", ramQ); end
        $display("reset_mid: ramQ=%h pulses=%0d", ramQ, pc_cyc.size());
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_rd_rf();
        test_loader();
        test_ready();
        test_reset_mid();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
